spi_regbank_slave: RTL and testbench

Parametrised successor SPI register-bank slave. Runs on a single system clock and oversamples the external SPI pins (sclk, csb, mosi, ldb); no logic is clocked by sclk. Holds NUM_CH words of DATA_W bits that are loaded in bulk from sensor inputs on an ldb falling edge, or read/written over SPI. Adds configurable width, depth and channel count, plus auto-increment burst access and a fabric write-notify port.

---
 rtl/spi_regbank_pkg.sv | 25 ++
 rtl/spi_pin_sync.sv | 47 ++++
 rtl/spi_regbank_slave.sv | 223 ++++++++++++++++++++++
 tb/tb_spi_regbank_slave.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_regbank_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_regbank_pkg
//  Purpose  : Shared types and constants for the SPI register-bank slave.
//  Revision : 1.0  initial release
// ============================================================================
package spi_regbank_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        ADDR = 2'd2,
        DATA = 2'd3
    } spi_state_t;

    localparam logic c_rw_write = 1'b0;
    localparam logic c_rw_read  = 1'b1;

    // Bits in one single-word frame: R/W, address, data.
    function automatic int FRAME_LEN(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_pin_sync.sv
`default_nettype none
// ============================================================================
//  Module   : spi_pin_sync
//  Purpose  : Two-flop synchroniser for an asynchronous pin plus registered
//             rise/fall pulse detection.
//  Revision : 1.0  initial release
// ============================================================================
module spi_pin_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic r_rise;
    logic r_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
            r_prev <= RST_VAL;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_meta <= i_pin;
            r_sync <= r_meta;
            r_prev <= r_sync;
            r_rise <= r_sync & ~r_prev;
            r_fall <= ~r_sync & r_prev;
        end
    end

    // Level is taken from the same stage as the pulses so both agree in time.
    assign o_level = r_prev;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/spi_regbank_slave.sv
`default_nettype none
// ============================================================================
//  Module   : spi_regbank_slave
//  Purpose  : Oversampled SPI mode-0 slave over a flop-based register bank with
//             bulk sensor snapshot, burst access and a write-notify port.
//  Revision : 1.0  initial release
// ============================================================================
module spi_regbank_slave
    import spi_regbank_pkg::*;
#(
    parameter int DATA_W   = 11,
    parameter int ADDR_W   = 4,
    parameter int NUM_CH   = 16,
    parameter int BURST_EN = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sclk,
    input  logic                     csb,
    input  logic                     mosi,
    output logic                     miso,
    output logic                     miso_oe,
    input  logic                     ldb,
    input  logic [NUM_CH*DATA_W-1:0] sensor_data,
    output logic                     wr_valid,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [DATA_W-1:0]        wr_data,
    output logic                     snap_done,
    output logic                     frame_err
);

    localparam int CNT_W = $clog2(((ADDR_W > DATA_W) ? ADDR_W : DATA_W) + 1);

    logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
    logic w_csb_lvl,  w_csb_rise,  w_csb_fall;
    logic w_mosi_lvl, w_mosi_rise, w_mosi_fall;
    logic w_ldb_lvl,  w_ldb_rise,  w_ldb_fall;
    logic w_unused;

    spi_pin_sync #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .i_pin(sclk),
        .o_level(w_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall));
    spi_pin_sync #(.RST_VAL(1'b1)) u_sync_csb (
        .clk(clk), .rst(rst), .i_pin(csb),
        .o_level(w_csb_lvl), .o_rise(w_csb_rise), .o_fall(w_csb_fall));
    spi_pin_sync #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .i_pin(mosi),
        .o_level(w_mosi_lvl), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall));
    spi_pin_sync #(.RST_VAL(1'b1)) u_sync_ldb (
        .clk(clk), .rst(rst), .i_pin(ldb),
        .o_level(w_ldb_lvl), .o_rise(w_ldb_rise), .o_fall(w_ldb_fall));

    assign w_unused = ^{w_sclk_lvl, w_csb_lvl, w_mosi_rise, w_mosi_fall, w_ldb_lvl, w_ldb_rise};

    spi_state_t          r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic                r_rw;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_shift_in;
    logic [DATA_W-1:0]   r_shift_out;
    logic                r_miso, r_miso_oe;
    logic                r_load_pend;
    logic                r_cm_pend;
    logic [ADDR_W-1:0]   r_cm_addr;
    logic [DATA_W-1:0]   r_cm_data;
    logic [DATA_W-1:0]   r_bank [NUM_CH];
    logic                r_wr_valid, r_snap_done, r_frame_err;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [DATA_W-1:0]   r_wr_data;

    logic                w_rise_ok, w_addr_last, w_word_last, w_frame_err;
    logic                w_snap, w_commit;
    logic [ADDR_W-1:0]   w_addr_shift, w_addr_inc;
    logic [DATA_W-1:0]   w_data_shift, w_rd_word;

    // csb release takes priority over an sclk edge seen in the same clk.
    assign w_rise_ok    = w_sclk_rise & ~w_csb_rise;
    assign w_addr_last  = (r_state == ADDR) && w_rise_ok && (r_bit_cnt == CNT_W'(ADDR_W - 1));
    assign w_word_last  = (r_state == DATA) && w_rise_ok && (r_bit_cnt == CNT_W'(DATA_W - 1));
    assign w_addr_shift = (r_addr << 1) | ADDR_W'(w_mosi_lvl);
    assign w_data_shift = (r_shift_in << 1) | DATA_W'(w_mosi_lvl);
    assign w_addr_inc   = (int'(r_addr) >= NUM_CH - 1) ? '0 : r_addr + ADDR_W'(1);
    assign w_snap       = w_ldb_fall;
    assign w_commit     = r_cm_pend && (int'(r_cm_addr) < NUM_CH) && !w_snap;

    always_comb begin
        w_rd_word = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (int'(r_addr) == k) w_rd_word = r_bank[k];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_frame_err = 1'b0;
        if (w_csb_rise) begin
            w_state_nxt = IDLE;
            w_frame_err = (r_state == ADDR) || ((r_state == DATA) && (r_bit_cnt != '0));
        end else begin
            case (r_state)
                IDLE:    if (w_csb_fall) w_state_nxt = CMD;
                CMD:     if (w_rise_ok) w_state_nxt = ADDR;
                ADDR:    if (w_addr_last) w_state_nxt = DATA;
                DATA:    if (w_word_last && (BURST_EN == 0)) w_state_nxt = CMD;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt   <= '0;
            r_rw        <= 1'b0;
            r_addr      <= '0;
            r_shift_in  <= '0;
            r_load_pend <= 1'b0;
            r_cm_pend   <= 1'b0;
            r_cm_addr   <= '0;
            r_cm_data   <= '0;
        end else begin
            r_load_pend <= 1'b0;
            r_cm_pend   <= 1'b0;
            if (w_csb_rise || (r_state == IDLE)) begin
                r_bit_cnt <= '0;
            end else if (w_rise_ok) begin
                case (r_state)
                    CMD: begin
                        r_rw      <= w_mosi_lvl;
                        r_bit_cnt <= '0;
                    end
                    ADDR: begin
                        r_addr <= w_addr_shift;
                        if (w_addr_last) begin
                            r_bit_cnt   <= '0;
                            r_load_pend <= (r_rw == c_rw_read);
                        end else begin
                            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        end
                    end
                    DATA: begin
                        r_shift_in <= w_data_shift;
                        if (w_word_last) begin
                            r_bit_cnt <= '0;
                            r_cm_pend <= (r_rw == c_rw_write);
                            r_cm_addr <= r_addr;
                            r_cm_data <= w_data_shift;
                            if (BURST_EN != 0) begin
                                r_addr      <= w_addr_inc;
                                r_load_pend <= (r_rw == c_rw_read);
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        end
                    end
                    default: r_bit_cnt <= '0;
                endcase
            end
        end
    end

    // Read shifter: load one clk after the address/word boundary, shift on falls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift_out <= '0;
            r_miso      <= 1'b0;
            r_miso_oe   <= 1'b0;
        end else if (w_csb_rise || (w_word_last && (BURST_EN == 0))) begin
            r_miso      <= 1'b0;
            r_miso_oe   <= 1'b0;
        end else if (r_load_pend) begin
            r_shift_out <= w_rd_word;
            r_miso      <= 1'b0;
            r_miso_oe   <= 1'b1;
        end else if (w_sclk_fall && r_miso_oe) begin
            r_miso      <= r_shift_out[DATA_W-1];
            r_shift_out <= r_shift_out << 1;
        end
    end

    // A snapshot in the same clk as a commit overrides it for every channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_CH; k++) r_bank[k] <= '0;
        end else if (w_snap) begin
            for (int k = 0; k < NUM_CH; k++) r_bank[k] <= sensor_data[k*DATA_W +: DATA_W];
        end else if (w_commit) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (int'(r_cm_addr) == k) r_bank[k] <= r_cm_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_valid  <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_snap_done <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_wr_valid  <= w_commit;
            r_wr_addr   <= w_commit ? r_cm_addr : '0;
            r_wr_data   <= w_commit ? r_cm_data : '0;
            r_snap_done <= w_snap;
            r_frame_err <= w_frame_err;
        end
    end

    assign miso      = r_miso_oe & r_miso;
    assign miso_oe   = r_miso_oe;
    assign wr_valid  = r_wr_valid;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign snap_done = r_snap_done;
    assign frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_regbank_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_regbank_slave
//  Purpose  : Directed bench for spi_regbank_slave (16-channel burst instance
//             and a 12-channel non-burst instance sharing the SPI pins).
//  Revision : 1.0  initial release
// ============================================================================
module tb_spi_regbank_slave;
    import spi_regbank_pkg::*;

    localparam int DW    = 11;
    localparam int AW    = 4;
    localparam int NCH   = 16;
    localparam int NCH_B = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sclk = 1'b0, mosi = 1'b0, ldb = 1'b1;
    logic csb_a = 1'b1, csb_b = 1'b1;
    logic [NCH*DW-1:0]   sens_a = '0;
    logic [NCH_B*DW-1:0] sens_b = '0;

    logic miso_a, oe_a, wrv_a, snap_a, ferr_a;
    logic miso_b, oe_b, wrv_b, snap_b, ferr_b;
    logic [AW-1:0] wra_a, wra_b;
    logic [DW-1:0] wrd_a, wrd_b;

    always #5 clk = ~clk;

    spi_regbank_slave #(.DATA_W(DW), .ADDR_W(AW), .NUM_CH(NCH), .BURST_EN(1)) dut_a (
        .clk(clk), .rst(rst), .sclk(sclk), .csb(csb_a), .mosi(mosi),
        .miso(miso_a), .miso_oe(oe_a), .ldb(ldb), .sensor_data(sens_a),
        .wr_valid(wrv_a), .wr_addr(wra_a), .wr_data(wrd_a),
        .snap_done(snap_a), .frame_err(ferr_a));

    spi_regbank_slave #(.DATA_W(DW), .ADDR_W(AW), .NUM_CH(NCH_B), .BURST_EN(0)) dut_b (
        .clk(clk), .rst(rst), .sclk(sclk), .csb(csb_b), .mosi(mosi),
        .miso(miso_b), .miso_oe(oe_b), .ldb(ldb), .sensor_data(sens_b),
        .wr_valid(wrv_b), .wr_addr(wra_b), .wr_data(wrd_b),
        .snap_done(snap_b), .frame_err(ferr_b));

    int n_chk = 0;
    int n_err = 0;
    int wr_cnt_a = 0, wr_cnt_b = 0, snap_cnt_a = 0, ferr_cnt_a = 0, ferr_cnt_b = 0;
    logic [AW-1:0] wr_addr_log [$];
    logic [DW-1:0] wr_data_log [$];
    logic [DW-1:0] tx_w [4];
    logic [DW-1:0] rx_w [4];
    int oe_low;

    always @(negedge clk) begin
        if (wrv_a) begin
            wr_cnt_a++;
            wr_addr_log.push_back(wra_a);
            wr_data_log.push_back(wrd_a);
        end
        if (wrv_b)  wr_cnt_b++;
        if (snap_a) snap_cnt_a++;
        if (ferr_a) ferr_cnt_a++;
        if (ferr_b) ferr_cnt_b++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One SPI bit; optionally drop ldb one clk after the sclk rise.
    task automatic spi_bit(input bit sel_b, input logic b, input bit chk_oe,
                           input bit ldb_drop, output logic m);
        mosi = b;
        tick(5);
        sclk = 1'b1;
        m = sel_b ? miso_b : miso_a;
        if (chk_oe && !(sel_b ? oe_b : oe_a)) oe_low++;
        if (ldb_drop) begin
            tick(1);
            ldb = 1'b0;
            tick(4);
        end else begin
            tick(5);
        end
        sclk = 1'b0;
    endtask

    task automatic spi_frame(input bit sel_b, input logic rw, input logic [AW-1:0] addr,
                             input int nbits, input bit collide);
        logic m;
        oe_low = 0;
        for (int k = 0; k < 4; k++) rx_w[k] = '0;
        if (sel_b) csb_b = 1'b0; else csb_a = 1'b0;
        tick(10);
        spi_bit(sel_b, rw, 1'b0, 1'b0, m);
        for (int i = 0; i < FRAME_LEN(AW, DW) - DW - 1; i++)
            spi_bit(sel_b, addr[AW-1-i], 1'b0, 1'b0, m);
        for (int i = 0; i < nbits; i++) begin
            spi_bit(sel_b, tx_w[i/DW][DW-1-(i%DW)], rw, collide && (i == nbits - 1), m);
            rx_w[i/DW][DW-1-(i%DW)] = m;
        end
        tick(10);
        if (sel_b) csb_b = 1'b1; else csb_a = 1'b1;
        ldb = 1'b1;
        tick(10);
    endtask

    initial begin
        tick(3);
        rst = 1'b0;
        tick(3);
        chk("rst_wr_valid",  wrv_a,  0);
        chk("rst_wr_data",   wrd_a,  0);
        chk("rst_miso_oe",   oe_a,   0);
        chk("rst_miso",      miso_a, 0);
        chk("rst_snap_done", snap_a, 0);
        chk("rst_frame_err", ferr_a, 0);
        spi_frame(1'b0, 1'b1, 4'd9, DW, 1'b0);
        chk("rst_bank9", rx_w[0], 0);

        // Write then read back
        tx_w[0] = 11'h5A3;
        spi_frame(1'b0, 1'b0, 4'd7, DW, 1'b0);
        chk("t1_wr_cnt",  wr_cnt_a, 1);
        chk("t1_wr_addr", wr_addr_log[0], 7);
        chk("t1_wr_data", wr_data_log[0], 32'h5A3);
        spi_frame(1'b0, 1'b1, 4'd7, DW, 1'b0);
        chk("t1_rd",       rx_w[0], 32'h5A3);
        chk("t1_oe_data",  oe_low,  0);
        chk("t1_oe_after", oe_a,    0);

        // Burst write wrapping 15 -> 0 -> 1, then burst read
        tx_w[0] = 11'h001; tx_w[1] = 11'h002; tx_w[2] = 11'h003;
        spi_frame(1'b0, 1'b0, 4'd15, 3*DW, 1'b0);
        chk("t2_wr_cnt", wr_cnt_a, 4);
        chk("t2_addr0",  wr_addr_log[1], 15);
        chk("t2_addr1",  wr_addr_log[2], 0);
        chk("t2_addr2",  wr_addr_log[3], 1);
        chk("t2_data2",  wr_data_log[3], 3);
        spi_frame(1'b0, 1'b1, 4'd15, 3*DW, 1'b0);
        chk("t2_rd15", rx_w[0], 1);
        chk("t2_rd0",  rx_w[1], 2);
        chk("t2_rd1",  rx_w[2], 3);
        chk("t2_oe",   oe_low,  0);

        // Snapshot of k*0x41
        for (int k = 0; k < NCH; k++) sens_a[k*DW +: DW] = DW'(k * 32'h41);
        ldb = 1'b0;
        tick(10);
        ldb = 1'b1;
        tick(10);
        chk("t3_snap_cnt", snap_cnt_a, 1);
        spi_frame(1'b0, 1'b1, 4'd3, DW, 1'b0);
        chk("t3_rd3", rx_w[0], 32'h0C3);
        spi_frame(1'b0, 1'b1, 4'd12, DW, 1'b0);
        chk("t3_rd12", rx_w[0], 32'h30C);

        // Snapshot lands on the same clk as the commit of 0x7FF to addr 2
        for (int k = 0; k < NCH; k++) sens_a[k*DW +: DW] = DW'(32'h400 | k);
        tx_w[0] = 11'h7FF;
        spi_frame(1'b0, 1'b0, 4'd2, DW, 1'b1);
        chk("t4_wr_cnt",   wr_cnt_a,   4);
        chk("t4_snap_cnt", snap_cnt_a, 2);
        spi_frame(1'b0, 1'b1, 4'd2, DW, 1'b0);
        chk("t4_rd2", rx_w[0], 32'h402);
        spi_frame(1'b0, 1'b1, 4'd9, DW, 1'b0);
        chk("t4_rd9", rx_w[0], 32'h409);

        // Abort after 6 data bits
        tx_w[0] = 11'h155;
        spi_frame(1'b0, 1'b0, 4'd4, 6, 1'b0);
        chk("t5_ferr_cnt", ferr_cnt_a, 1);
        chk("t5_wr_cnt",   wr_cnt_a,   4);
        spi_frame(1'b0, 1'b1, 4'd4, DW, 1'b0);
        chk("t5_rd4_kept", rx_w[0], 32'h404);
        spi_frame(1'b0, 1'b0, 4'd4, DW, 1'b0);
        chk("t5_wr_cnt_next", wr_cnt_a, 5);
        spi_frame(1'b0, 1'b1, 4'd4, DW, 1'b0);
        chk("t5_rd4_new",   rx_w[0],    32'h155);
        chk("t5_ferr_only", ferr_cnt_a, 1);

        // 12-channel instance: out-of-range and top valid address
        tx_w[0] = 11'h123;
        spi_frame(1'b1, 1'b0, 4'd13, DW, 1'b0);
        chk("t6_oor_wr_cnt", wr_cnt_b, 0);
        spi_frame(1'b1, 1'b1, 4'd13, DW, 1'b0);
        chk("t6_oor_rd", rx_w[0], 0);
        tx_w[0] = 11'h2BC;
        spi_frame(1'b1, 1'b0, 4'd11, DW, 1'b0);
        chk("t6_wr_cnt11", wr_cnt_b, 1);
        spi_frame(1'b1, 1'b1, 4'd11, DW, 1'b0);
        chk("t6_rd11",    rx_w[0],    32'h2BC);
        chk("t6_oe_data", oe_low,     0);
        chk("t6_oe_off",  oe_b,       0);
        chk("t6_ferr",    ferr_cnt_b, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
